// File: rtl/hamm_enc_arb.sv
// Round-robin scheduler that shares one Hamming(12,8) encoder between two byte requesters.
// Results leave through a registered valid/ready port, and delivered codewords are counted per source.

module hamm_enc (
  input  logic [7:0]  IN,
  output logic [11:0] HAMM_OUT,
  output logic        OUT_PARITY
);

  logic p1, p2, p4, p8;

  // Codeword position n (1-based) sits at HAMM_OUT[n-1].
  // Check bits sit at positions 1, 2, 4 and 8.
  always_comb begin
    p1         = IN[0] ^ IN[1] ^ IN[3] ^ IN[4] ^ IN[6];
    p2         = IN[0] ^ IN[2] ^ IN[3] ^ IN[5] ^ IN[6];
    p4         = IN[1] ^ IN[2] ^ IN[3] ^ IN[7];
    p8         = IN[4] ^ IN[5] ^ IN[6] ^ IN[7];
    HAMM_OUT   = {IN[7:4], p8, IN[3:1], p4, IN[0], p2, p1};
    OUT_PARITY = ^HAMM_OUT;
  end

endmodule

module hamm_enc_arb #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  A_VALID,
  input  logic [DATA_WIDTH-1:0] A_DATA,
  output logic                  A_READY,
  input  logic                  B_VALID,
  input  logic [DATA_WIDTH-1:0] B_DATA,
  output logic                  B_READY,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [11:0]           OUT_CODE,
  output logic                  OUT_PARITY,
  output logic                  OUT_SRC,
  output logic [CNT_WIDTH-1:0]  A_COUNT,
  output logic [CNT_WIDTH-1:0]  B_COUNT,
  output logic                  BUSY
);

  typedef enum logic [1:0] {StIdle, StEnc, StSend} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] enc_q;
  logic                  src_q;
  logic                  last_src_q;
  logic [11:0]           code_q;
  logic                  parity_q;
  logic                  out_src_q;
  logic                  out_valid_q;
  logic [CNT_WIDTH-1:0]  a_cnt_q, a_cnt_d;
  logic [CNT_WIDTH-1:0]  b_cnt_q, b_cnt_d;

  logic                  grant_a, grant_b;
  logic                  accept_a, accept_b, accept;
  logic                  out_hs;
  logic [11:0]           enc_code;
  logic                  enc_parity;

  hamm_enc u_hamm_enc (
    .IN        (enc_q),
    .HAMM_OUT  (enc_code),
    .OUT_PARITY(enc_parity)
  );

  // On a tie the grant goes to whichever source did not win last time.
  always_comb begin
    grant_a = A_VALID & (~B_VALID | last_src_q);
    grant_b = B_VALID & (~A_VALID | ~last_src_q);
  end

  always_comb begin
    accept_a = A_VALID & A_READY;
    accept_b = B_VALID & B_READY;
    accept   = accept_a | accept_b;
    out_hs   = out_valid_q & OUT_READY;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StEnc;
      StEnc:   state_d = StSend;
      StSend:  if (out_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The reset term keeps both READYs low while rst is high, even though state is already idle.
  always_comb begin
    A_READY = 1'b0;
    B_READY = 1'b0;
    BUSY    = (state_q != StIdle);
    if (state_q == StIdle && !rst) begin
      A_READY = grant_a;
      B_READY = grant_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_q      <= '0;
      src_q      <= 1'b0;
      last_src_q <= 1'b1;
    end else if (accept) begin
      enc_q      <= accept_b ? B_DATA : A_DATA;
      src_q      <= accept_b;
      last_src_q <= accept_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q      <= '0;
      parity_q    <= 1'b0;
      out_src_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (state_q == StEnc) begin
      code_q      <= enc_code;
      parity_q    <= enc_parity;
      out_src_q   <= src_q;
      out_valid_q <= 1'b1;
    end else if (out_hs) begin
      out_valid_q <= 1'b0;
    end
  end

  // Counters advance only when a codeword actually leaves; wrap is silent.
  always_comb begin
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (out_hs) begin
      if (out_src_q) begin
        b_cnt_d = b_cnt_q + 1'b1;
      end else begin
        a_cnt_d = a_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  always_comb begin
    OUT_VALID  = out_valid_q;
    OUT_CODE   = code_q;
    OUT_PARITY = parity_q;
    OUT_SRC    = out_src_q;
    A_COUNT    = a_cnt_q;
    B_COUNT    = b_cnt_q;
  end

endmodule

// File: tb/tb_hamm_enc_arb.sv
// Directed bench for hamm_enc_arb, with a scoreboard of expected codewords in grant order.
// A second instance with 2-bit counters shares the stimulus so that counter wrap can be observed.

module tb_hamm_enc_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        A_VALID, B_VALID, OUT_READY;
  logic [7:0]  A_DATA, B_DATA;
  logic        A_READY, B_READY, OUT_VALID, OUT_PARITY, OUT_SRC, BUSY;
  logic [11:0] OUT_CODE;
  logic [15:0] A_COUNT, B_COUNT;

  logic        w_a_ready, w_b_ready, w_out_valid, w_out_parity, w_out_src, w_busy;
  logic [11:0] w_out_code;
  logic [1:0]  w_a_count, w_b_count;

  always #5 clk = ~clk;

  hamm_enc_arb #(.DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst),
    .A_VALID(A_VALID), .A_DATA(A_DATA), .A_READY(A_READY),
    .B_VALID(B_VALID), .B_DATA(B_DATA), .B_READY(B_READY),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_CODE(OUT_CODE),
    .OUT_PARITY(OUT_PARITY), .OUT_SRC(OUT_SRC),
    .A_COUNT(A_COUNT), .B_COUNT(B_COUNT), .BUSY(BUSY)
  );

  hamm_enc_arb #(.DATA_WIDTH(8), .CNT_WIDTH(2)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .A_VALID(A_VALID), .A_DATA(A_DATA), .A_READY(w_a_ready),
    .B_VALID(B_VALID), .B_DATA(B_DATA), .B_READY(w_b_ready),
    .OUT_VALID(w_out_valid), .OUT_READY(OUT_READY), .OUT_CODE(w_out_code),
    .OUT_PARITY(w_out_parity), .OUT_SRC(w_out_src),
    .A_COUNT(w_a_count), .B_COUNT(w_b_count), .BUSY(w_busy)
  );

  typedef struct packed {
    logic        src;
    logic [11:0] code;
    logic        par;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  a_bytes[$], b_bytes[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_a_cnt, exp_b_cnt;
  int          cyc = 0;
  int          last_hs;
  bit          spacing_on = 1'b0;
  logic [12:0] m_tmp;

  // Reference encoder: data fills non-power-of-two positions, and check bit 2^b covers every
  // position that has bit b set.
  function automatic logic [12:0] model(input logic [7:0] d);
    logic [12:1] pos;
    logic        x;
    int          k;
    pos = '0;
    k   = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        pos[p] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      x = 1'b0;
      for (int p = 1; p <= 12; p++) begin
        if ((p & (1 << b)) != 0) x ^= pos[p];
      end
      pos[1 << b] = x;
    end
    return {^pos, pos};
  endfunction

  function automatic exp_t mk(input logic s, input logic [7:0] d);
    logic [12:0] m;
    m = model(d);
    return {s, m[11:0], m[12]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    A_VALID = (a_bytes.size() != 0);
    B_VALID = (b_bytes.size() != 0);
    A_DATA  = 8'h00;
    B_DATA  = 8'h00;
    if (A_VALID) A_DATA = a_bytes[0];
    if (B_VALID) B_DATA = b_bytes[0];
  endtask

  // One clock: sample handshakes at the falling edge, then advance producers and check counts.
  task automatic step();
    logic a_fire, b_fire, hs;
    exp_t e;
    @(negedge clk);
    a_fire = A_VALID && A_READY;
    b_fire = B_VALID && B_READY;
    hs     = OUT_VALID && OUT_READY;
    if (hs) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_out", 32'(OUT_VALID), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("sb_src", 32'(OUT_SRC), 32'(e.src));
        check("sb_code", 32'(OUT_CODE), 32'(e.code));
        check("sb_parity", 32'(OUT_PARITY), 32'(e.par));
        if (e.src) exp_b_cnt++;
        else exp_a_cnt++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (a_fire) void'(a_bytes.pop_front());
    if (b_fire) void'(b_bytes.pop_front());
    drive();
    if (hs) begin
      check("a_count", 32'(A_COUNT), 32'(exp_a_cnt));
      check("b_count", 32'(B_COUNT), 32'(exp_b_cnt));
      check("wrap_a_count", 32'(w_a_count), 32'(exp_a_cnt & 3));
      check("wrap_b_count", 32'(w_b_count), 32'(exp_b_cnt & 3));
      if (spacing_on && last_hs >= 0) check("out_spacing", 32'(cyc - last_hs), 32'(3));
      last_hs = cyc;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) step();
    check(tag, 32'(exp_q.size()), 32'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_bytes.delete();
    b_bytes.delete();
    exp_q.delete();
    drive();
    exp_a_cnt = 0;
    exp_b_cnt = 0;
    last_hs   = -1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with both requesters valid
    rst = 1'b1;
    OUT_READY = 1'b1;
    A_VALID = 1'b1;
    B_VALID = 1'b1;
    A_DATA = 8'h5A;
    B_DATA = 8'hA5;
    #12;
    check("rst_a_ready", 32'(A_READY), 32'(0));
    check("rst_b_ready", 32'(B_READY), 32'(0));
    check("rst_out_valid", 32'(OUT_VALID), 32'(0));
    check("rst_out_code", 32'(OUT_CODE), 32'(0));
    check("rst_out_parity", 32'(OUT_PARITY), 32'(0));
    check("rst_out_src", 32'(OUT_SRC), 32'(0));
    check("rst_a_count", 32'(A_COUNT), 32'(0));
    check("rst_b_count", 32'(B_COUNT), 32'(0));
    check("rst_busy", 32'(BUSY), 32'(0));
    do_reset();

    // Single word from A
    OUT_READY = 1'b1;
    a_bytes.push_back(8'hC4);
    exp_q.push_back(mk(1'b0, 8'hC4));
    drive();
    #1;
    check("single_a_ready", 32'(A_READY), 32'(1));
    check("single_b_ready", 32'(B_READY), 32'(0));
    step();
    check("single_enc_valid", 32'(OUT_VALID), 32'(0));
    check("single_enc_busy", 32'(BUSY), 32'(1));
    step();
    check("single_valid", 32'(OUT_VALID), 32'(1));
    step();
    check("single_valid_one_cycle", 32'(OUT_VALID), 32'(0));
    check("single_a_count", 32'(A_COUNT), 32'(1));
    check("single_idle", 32'(BUSY), 32'(0));

    // Contention: both continuously valid
    do_reset();
    OUT_READY = 1'b1;
    spacing_on = 1'b1;
    a_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    b_bytes = '{8'hA5, 8'h5A, 8'hF0, 8'h0F};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(1'b0, a_bytes[i]));
      exp_q.push_back(mk(1'b1, b_bytes[i]));
    end
    drive();
    drain("contention_drain");
    spacing_on = 1'b0;
    check("contention_a_count", 32'(A_COUNT), 32'(4));
    check("contention_b_count", 32'(B_COUNT), 32'(4));

    // Backpressure: 10 cycles stalled in SEND
    do_reset();
    OUT_READY = 1'b0;
    a_bytes = '{8'h3C, 8'h77};
    b_bytes = '{8'h99};
    exp_q.push_back(mk(1'b0, 8'h3C));
    exp_q.push_back(mk(1'b1, 8'h99));
    exp_q.push_back(mk(1'b0, 8'h77));
    drive();
    step();
    step();
    m_tmp = model(8'h3C);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(OUT_VALID), 32'(1));
      check("bp_code", 32'(OUT_CODE), 32'(m_tmp[11:0]));
      check("bp_parity", 32'(OUT_PARITY), 32'(m_tmp[12]));
      check("bp_ready", 32'({A_READY, B_READY}), 32'(0));
      check("bp_a_count", 32'(A_COUNT), 32'(0));
      step();
    end
    OUT_READY = 1'b1;
    step();
    check("bp_release_count", 32'(A_COUNT), 32'(1));
    drain("bp_drain");

    // Wrap on the 2-bit instance: 5 B words
    do_reset();
    OUT_READY = 1'b1;
    b_bytes = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h6D};
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(1'b1, b_bytes[i]));
    drive();
    drain("wrap_drain");
    check("wrap_final_b", 32'(w_b_count), 32'(1));
    check("wrap_final_a", 32'(w_a_count), 32'(0));

    // Reset while a B codeword waits in SEND
    do_reset();
    OUT_READY = 1'b0;
    b_bytes.push_back(8'hB7);
    drive();
    step();
    step();
    check("rs_valid_before", 32'(OUT_VALID), 32'(1));
    check("rs_src_before", 32'(OUT_SRC), 32'(1));
    OUT_READY = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("rs_valid_async", 32'(OUT_VALID), 32'(0));
    check("rs_busy_async", 32'(BUSY), 32'(0));
    check("rs_b_count_async", 32'(B_COUNT), 32'(0));
    @(posedge clk);
    #1;
    check("rs_b_count_edge", 32'(B_COUNT), 32'(0));
    do_reset();
    OUT_READY = 1'b1;
    a_bytes.push_back(8'hA1);
    b_bytes.push_back(8'hB1);
    exp_q.push_back(mk(1'b0, 8'hA1));
    exp_q.push_back(mk(1'b1, 8'hB1));
    drive();
    drain("rs_drain");

    // Reset in ENC after an A accept: the tie priority must return to A
    do_reset();
    OUT_READY = 1'b1;
    a_bytes.push_back(8'hC1);
    drive();
    step();
    check("re_busy", 32'(BUSY), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    check("re_busy_async", 32'(BUSY), 32'(0));
    do_reset();
    a_bytes.push_back(8'hD1);
    b_bytes.push_back(8'hD2);
    exp_q.push_back(mk(1'b0, 8'hD1));
    exp_q.push_back(mk(1'b1, 8'hD2));
    drive();
    drain("re_drain");
    check("re_a_count", 32'(A_COUNT), 32'(1));
    check("re_b_count", 32'(B_COUNT), 32'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
